// File: rtl/gfp8_result_packer.sv
// Converts the GFP result stream (mantissa * 2^exponent) to FP16 and packs
// LANES results per line into the result BRAM, flushing the partial line on tile done.
module gfp8_result_packer #(
    parameter int LANES  = 16,
    parameter int ADDR_W = 9
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [ADDR_W-1:0]       i_base_addr,
    input  logic                    i_result_valid,
    input  logic signed [31:0]      i_result_mantissa,
    input  logic signed [7:0]       i_result_exponent,
    input  logic                    i_tile_done,
    output logic                    o_wr_en,
    output logic [ADDR_W-1:0]       o_wr_addr,
    output logic [LANES*16-1:0]     o_wr_data,
    output logic                    o_done,
    output logic                    o_busy,
    output logic [15:0]             o_result_count,
    output logic                    o_drop_err
);

    localparam int LINE_W = LANES * 16;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

    state_t state, state_nxt;

    function automatic logic [5:0] msb_index(input logic [32:0] mag);
        msb_index = '0;
        for (int i = 0; i < 33; i++) begin
            if (mag[i]) msb_index = 6'(i);
        end
    endfunction

    // Truncating conversion with saturation to +/-max-normal and flush of tiny values to +0.
    function automatic logic [15:0] to_fp16(input logic sgn, input logic [32:0] mag,
                                            input logic [5:0] msb, input logic signed [7:0] expo);
        logic signed [9:0] e;
        logic [9:0]        frac;
        e    = $signed({4'b0, msb}) + $signed({{2{expo[7]}}, expo});
        frac = 10'((mag << (6'd32 - msb)) >> 22);
        if (mag == '0)
            to_fp16 = 16'h0000;
        else if (e > 10'sd15)
            to_fp16 = {sgn, 15'h7BFF};
        else if (e < -10'sd14)
            to_fp16 = 16'h0000;
        else
            to_fp16 = {sgn, 5'(e + 10'sd15), frac};
    endfunction

    logic                 accept_p0;
    logic                 sign_p0;
    logic signed [32:0]   mant_ext_p0;
    logic [32:0]          mag_p0;

    logic                 vld_p1, done_p1, sign_p1;
    logic [32:0]          mag_p1;
    logic [5:0]           msb_p1;
    logic signed [7:0]    exp_p1;

    logic                 vld_p2, done_p2;
    logic [15:0]          fp16_p2;

    logic [LANE_W-1:0]    lane;
    logic [ADDR_W-1:0]    addr;
    logic [LINE_W-1:0]    line_buf;
    logic [LINE_W-1:0]    line_nxt;
    logic                 flush_p2;

    // stage 0: magnitude and acceptance
    assign accept_p0   = i_result_valid && (i_start || state == COLLECT);
    assign sign_p0     = i_result_mantissa[31];
    assign mant_ext_p0 = {i_result_mantissa[31], i_result_mantissa};
    assign mag_p0      = sign_p0 ? -mant_ext_p0 : mant_ext_p0;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = COLLECT;
            COLLECT: if (i_start) state_nxt = COLLECT;
                     else if (o_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state == COLLECT);
    end

    // stage 1 / stage 2 data path
    always_ff @(posedge i_clk) begin
        sign_p1 <= sign_p0;
        mag_p1  <= mag_p0;
        msb_p1  <= msb_index(mag_p0);
        exp_p1  <= i_result_exponent;
        fp16_p2 <= to_fp16(sign_p1, mag_p1, msb_p1, exp_p1);
        if (vld_p2 && !i_start) line_buf <= line_nxt;
    end

    // stage 3: lanes above the current one read as zero, so a flushed partial line is clean
    always_comb begin
        line_nxt = '0;
        for (int k = 0; k < LANES; k++) begin
            if (LANE_W'(k) < lane)
                line_nxt[16*k +: 16] = line_buf[16*k +: 16];
            else if (LANE_W'(k) == lane)
                line_nxt[16*k +: 16] = fp16_p2;
        end
    end

    assign flush_p2 = vld_p2 && (lane == LANE_W'(LANES - 1) || done_p2);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vld_p1         <= 1'b0;
            done_p1        <= 1'b0;
            vld_p2         <= 1'b0;
            done_p2        <= 1'b0;
            lane           <= '0;
            addr           <= '0;
            o_wr_en        <= 1'b0;
            o_wr_addr      <= '0;
            o_wr_data      <= '0;
            o_done         <= 1'b0;
            o_result_count <= '0;
            o_drop_err     <= 1'b0;
        end else begin
            o_wr_en <= 1'b0;
            o_done  <= 1'b0;
            if (i_start) begin
                // a start discards everything in flight and re-arms
                vld_p1         <= i_result_valid;
                done_p1        <= i_result_valid && i_tile_done;
                vld_p2         <= 1'b0;
                done_p2        <= 1'b0;
                lane           <= '0;
                addr           <= i_base_addr;
                o_result_count <= {15'b0, i_result_valid};
                o_drop_err     <= 1'b0;
            end else begin
                vld_p1  <= accept_p0;
                done_p1 <= accept_p0 && i_tile_done;
                vld_p2  <= vld_p1;
                done_p2 <= done_p1;
                if (i_result_valid && state == IDLE) o_drop_err <= 1'b1;
                if (accept_p0 && o_result_count != 16'hFFFF)
                    o_result_count <= o_result_count + 16'd1;
                if (vld_p2) begin
                    if (flush_p2) begin
                        o_wr_en   <= 1'b1;
                        o_wr_addr <= addr;
                        o_wr_data <= line_nxt;
                        o_done    <= done_p2;
                        addr      <= addr + ADDR_W'(1);
                        lane      <= '0;
                    end else begin
                        lane <= lane + LANE_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gfp8_result_packer.sv
// Randomised scoreboard bench for gfp8_result_packer against a tile-level FP16 packing model.
module tb_gfp8_result_packer;

    localparam int LANES  = 16;
    localparam int ADDR_W = 9;

    logic                 i_clk = 1'b0;
    logic                 i_reset = 1'b1;
    logic                 i_start = 1'b0;
    logic [ADDR_W-1:0]    i_base_addr = '0;
    logic                 i_result_valid = 1'b0;
    logic [31:0]          i_result_mantissa = '0;
    logic [7:0]           i_result_exponent = '0;
    logic                 i_tile_done = 1'b0;
    logic                 o_wr_en;
    logic [ADDR_W-1:0]    o_wr_addr;
    logic [LANES*16-1:0]  o_wr_data;
    logic                 o_done;
    logic                 o_busy;
    logic [15:0]          o_result_count;
    logic                 o_drop_err;

    gfp8_result_packer #(.LANES(LANES), .ADDR_W(ADDR_W)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_result_valid(i_result_valid), .i_result_mantissa(i_result_mantissa),
        .i_result_exponent(i_result_exponent), .i_tile_done(i_tile_done),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_done(o_done),
        .o_busy(o_busy), .o_result_count(o_result_count), .o_drop_err(o_drop_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [ADDR_W-1:0]    addr;
        logic [LANES*16-1:0]  data;
        bit                   done;
        longint               cyc;
    } wr_t;

    wr_t          exp_q[$];
    logic [15:0]  m_vals[$];
    logic [ADDR_W-1:0] m_addr = '0;
    int           m_count = 0;
    bit           m_active = 0;
    bit           m_drop = 0;
    int           compared = 0;
    int           mismatched = 0;
    longint       cyc = 0;
    bit           done_seen = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Value = m * 2^x, truncated to FP16 with saturation, flush-to-+0 and no subnormals.
    function automatic logic [15:0] ref_fp16(input logic signed [31:0] m, input logic signed [7:0] x);
        longint mag;
        longint frac;
        int     p;
        int     e;
        logic   s;
        if (m == 0) return 16'h0000;
        s   = (m < 0);
        mag = s ? -longint'(m) : longint'(m);
        p   = 0;
        while ((mag >> (p + 1)) != 0) p++;
        e = p + int'(x);
        if (e > 15)  return s ? 16'hFBFF : 16'h7BFF;
        if (e < -14) return 16'h0000;
        frac = ((mag << 10) >> p) - 1024;
        return {s, 5'(e + 15), 10'(frac)};
    endfunction

    task automatic push_line(input bit d);
        wr_t w;
        w.data = '0;
        foreach (m_vals[i]) w.data[16*i +: 16] = m_vals[i];
        w.addr = m_addr;
        w.done = d;
        w.cyc  = cyc + 3;
        exp_q.push_back(w);
        m_addr = m_addr + 1'b1;
        m_vals.delete();
    endtask

    task automatic drive(input bit v, input logic [31:0] m, input logic [7:0] x, input bit d,
                         input bit st, input logic [ADDR_W-1:0] base);
        i_start = st; i_base_addr = base; i_result_valid = v;
        i_result_mantissa = m; i_result_exponent = x; i_tile_done = d;
        if (st) begin
            while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
            m_vals.delete();
            m_addr = base; m_count = 0; m_active = 1; m_drop = 0;
        end
        if (v) begin
            if (m_active) begin
                m_vals.push_back(ref_fp16(m, x));
                if (m_count != 65535) m_count++;
                if (m_vals.size() == LANES || d) push_line(d);
                if (d) m_active = 0;
            end else begin
                m_drop = 1;
            end
        end
        @(posedge i_clk); #1;
        i_start = 0; i_result_valid = 0; i_tile_done = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, '0, '0, 0, 0, '0);
    endtask

    task automatic elem(input logic [31:0] m, input logic [7:0] x, input bit d);
        drive(1, m, x, d, 0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"},   o_wr_en, 0);
        check({tag, "_wr_addr"}, o_wr_addr, 0);
        check({tag, "_wr_data"}, o_wr_data, 0);
        check({tag, "_done"},    o_done, 0);
        check({tag, "_busy"},    o_busy, 0);
        check({tag, "_count"},   o_result_count, 0);
        check({tag, "_drop"},    o_drop_err, 0);
    endtask

    function automatic logic [31:0] rand_mant();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0: v = 32'h0;
            1: v = 32'h80000000;
            2: v = 32'h7FFFFFFF;
            3, 4: v = $urandom_range(1, 4095);
            default: v = $urandom;
        endcase
        if ($urandom_range(0, 1) == 1 && v != 32'h80000000) v = -v;
        return v;
    endfunction

    function automatic logic [7:0] rand_exp();
        if ($urandom_range(0, 7) == 0) return 8'($urandom);
        return 8'(int'($urandom_range(0, 65)) - 45);
    endfunction

    // Scoreboard monitor: every presented write is matched against the oldest expected line.
    always @(negedge i_clk) begin
        wr_t w;
        if (i_reset) begin
            done_seen = 0;
        end else begin
            if (done_seen) begin
                check("busy_after_done", o_busy, 0);
                done_seen = 0;
            end
            if (o_wr_en) begin
                if (exp_q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", o_wr_addr, o_wr_data);
                end else begin
                    w = exp_q.pop_front();
                    check("wr_addr", o_wr_addr, w.addr);
                    check("wr_data", o_wr_data, w.data);
                    check("wr_done", o_done, w.done);
                    check("wr_cycle", cyc, w.cyc);
                    if (w.done) begin
                        check("busy_at_done", o_busy, 1);
                        done_seen = 1;
                    end
                end
            end else if (o_done) begin
                compared++; mismatched++;
                $display("FAIL done_without_write: got o_done=1, expected o_wr_en=1");
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] base;
        int len, cut;
        bit abort_t, with_start;

        repeat (3) @(posedge i_clk);
        #1;
        check_reset_outputs("por");
        i_reset = 0;
        idle(2);

        // conversion vectors
        drive(0, '0, '0, 0, 1, 9'h010);
        elem(32'd1, 8'd0, 0);
        elem(32'(-3), 8'(-1), 0);
        elem(32'd3, 8'd14, 0);
        elem(32'd1, 8'(-15), 1);
        idle(5); drain();
        check("count_vectors", o_result_count, 4);

        // saturation and extremes
        drive(0, '0, '0, 0, 1, 9'h030);
        elem(32'd1, 8'd16, 0);
        elem(32'(-1), 8'd16, 0);
        elem(32'h80000000, 8'd0, 0);
        elem(32'h7FFFFFFF, 8'(-20), 0);
        elem(32'd0, 8'd50, 1);
        idle(5); drain();

        // 40 back-to-back with address wrap
        drive(0, '0, '0, 0, 1, 9'h1FF);
        for (int i = 1; i <= 40; i++) elem(rand_mant(), rand_exp(), i == 40);
        idle(5); drain();
        check("count_40", o_result_count, 40);

        // exact fill
        drive(0, '0, '0, 0, 1, 9'h080);
        for (int i = 1; i <= 16; i++) elem(rand_mant(), rand_exp(), i == 16);
        idle(5); drain();
        check("count_16", o_result_count, 16);

        // abort with same-cycle start and element
        drive(0, '0, '0, 0, 1, 9'h100);
        for (int i = 0; i < 5; i++) elem(rand_mant(), rand_exp(), 0);
        drive(1, 32'd7, 8'd0, 1, 1, 9'h020);
        idle(5); drain();
        check("count_abort", o_result_count, 1);

        // idle drop, cleared by start
        drive(1, 32'd5, 8'd0, 0, 0, '0);
        check("drop_set", o_drop_err, 1);
        drive(0, '0, '0, 0, 1, 9'h050);
        check("drop_cleared", o_drop_err, 0);
        check("busy_armed", o_busy, 1);

        // randomised tiles, some aborted by the next start
        for (int t = 0; t < 40; t++) begin
            base       = ADDR_W'($urandom);
            len        = $urandom_range(1, 48);
            abort_t    = ($urandom_range(0, 5) == 0);
            cut        = $urandom_range(1, len);
            with_start = ($urandom_range(0, 1) == 1);
            if (!with_start) drive(0, '0, '0, 0, 1, base);
            for (int n = 1; n <= len; n++) begin
                if (abort_t && n > cut) break;
                if (!(with_start && n == 1) && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                drive(1, rand_mant(), rand_exp(), (n == len) && !abort_t, with_start && n == 1, base);
            end
            if (!abort_t) begin
                idle(5); drain();
                check("count_rand", o_result_count, m_count);
                if ($urandom_range(0, 3) == 0) drive(1, rand_mant(), rand_exp(), 0, 0, '0);
                check("drop_rand", o_drop_err, m_drop);
            end
        end
        idle(5); drain();

        // reset one cycle after a done element
        drive(0, '0, '0, 0, 1, 9'h040);
        elem(32'd9, 8'd0, 0);
        elem(32'd11, 8'd2, 1);
        i_reset = 1;
        exp_q.delete(); m_vals.delete();
        m_active = 0; m_count = 0; m_drop = 0; m_addr = '0;
        @(posedge i_clk); #1;
        check_reset_outputs("mid_rst");
        @(posedge i_clk); #1;
        i_reset = 0;
        idle(6);
        check("no_write_after_rst", exp_q.size(), 0);
        check("rst_busy_after", o_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
